// File: rtl/uart_rx.sv
// Byte-wide UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), 3-sample majority vote per bit.
// Received byte is held in data/valid until acknowledged with rd_ack.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       rd_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [9:0] CNT_LAST = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] CNT_HM1  = 10'(HALF - 1);
    localparam logic [9:0] CNT_HALF = 10'(HALF);
    localparam logic [9:0] CNT_HP1  = 10'(HALF + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic       sync1, rxs, rxs_d;
    logic [2:0] state;
    logic [9:0] cnt;
    logic [9:0] cnt_next;
    logic [2:0] bit_idx;
    logic [7:0] sh;
    logic       samp_a, samp_b;
    logic       fall, maj_pt, wrap, maj, commit, ack;
`ifdef UART_RX_PARITY_EN
    logic       par_bit;
`endif

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    // Third vote is the live rxs at cnt=HALF+1, so the decision is ready in that cycle.
    always_comb begin
        fall     = rxs_d & ~rxs;
        maj_pt   = (cnt == CNT_HP1);
        wrap     = (cnt == CNT_LAST);
        cnt_next = wrap ? '0 : cnt + 10'd1;
        maj      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
        commit   = (state == S_STOP) && maj_pt;
        ack      = valid & rd_ack;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (state != S_IDLE && state != S_BREAK) begin
                cnt <= cnt_next;
                if (cnt == CNT_HM1) samp_a <= rxs;
                if (cnt == CNT_HALF) samp_b <= rxs;
            end
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (maj_pt && maj) begin
                        state <= S_IDLE;
                    end else if (wrap) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (maj_pt) sh <= {maj, sh[7:1]};
                    if (wrap) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (maj_pt) par_bit <= maj;
                    if (wrap) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (maj_pt) state <= maj ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A commit coinciding with rd_ack replaces the old byte in place; valid never drops.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (commit && (!valid || ack)) begin
                data       <= sh;
                frame_err  <= ~maj;
                valid      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= (^sh) ^ par_bit;
`endif
                if (ack) overrun <= 1'b0;
            end else if (commit) begin
                overrun <= 1'b1;
            end else if (ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at CLKS_PER_BIT=16; expectations queued at frame start,
// popped by a monitor whenever the receiver presents a new byte.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // start drive -> 3 edges to enter START, NBITS bit periods to stop bit, vote at HALF+1, commit edge
    localparam int LAT = 3 + NBITS * CPB + HALF + 2;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       bz;
        int         t0;
    } exp_t;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rd_ack;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .rd_ack    (rd_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #10 clk_50m = ~clk_50m;
    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50m);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip, input bit expect_it);
        exp_t e;
        rxd = 1'b0;
        if (expect_it) begin
            e.d  = d;
            e.fe = ~stop;
            e.pe = pflip;
            e.bz = ~stop;
            e.t0 = cyc;
            exp_q.push_back(e);
        end
        tick(CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ pflip);
`endif
        drive_bit(stop);
    endtask

    task automatic wait_valid(input int maxc);
        int k = 0;
        while (!valid && k < maxc) begin
            tick(1);
            k++;
        end
        check("wait_valid", valid, 1);
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
        check("rst_parity_err", parity_err, 0);
`endif
    endtask

    // Monitor: a new byte is a rising valid, or valid still high after an acked cycle.
    logic prev_v = 1'b0;
    logic prev_a = 1'b0;
    always @(negedge clk_50m) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_a = 1'b0;
        end else begin
            if (valid && (!prev_v || prev_a)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    int   lat;
                    e   = exp_q.pop_front();
                    lat = cyc - e.t0;
                    check("sb_data", data, e.d);
                    check("sb_frame_err", frame_err, e.fe);
                    check("sb_busy_at_commit", busy, e.bz);
`ifdef UART_RX_PARITY_EN
                    check("sb_parity_err", parity_err, e.pe);
`endif
                    n_checks++;
                    if (lat < LAT - 1 || lat > LAT) begin
                        n_fail++;
                        $display("FAIL sb_latency: got %0d cycles expected %0d..%0d", lat, LAT - 1, LAT);
                    end
                end
            end
            prev_v = valid;
            prev_a = rd_ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        logic       rs, rp;
        int         c2;

        rst    = 1'b1;
        rxd    = 1'b1;
        rd_ack = 1'b0;
        tick(3);
        check_reset_outputs();
        rst = 1'b0;
        tick(5);

        // clean byte
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        wait_valid(50);
        check("a5_data", data, 8'hA5);
        ack_pulse();
        check("a5_acked", valid, 0);

        // 3-cycle glitch on idle line
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(3);
        check("glitch_busy", busy, 1);
        tick(30);
        check("glitch_valid", valid, 0);
        check("glitch_idle", busy, 0);

        // low stop bit, line held low
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        tick(24);
        check("break_busy", busy, 1);
        check("break_fe", frame_err, 1);
        check("break_data", data, 8'h3C);
        rxd = 1'b1;
        tick(10);
        check("break_exit", busy, 0);
        ack_pulse();
        tick(40);
        check("break_no_phantom", valid, 0);

        // overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        tick(4);
        check("ovr_valid", valid, 1);
        check("ovr_data", data, 8'h11);
        check("ovr_flag", overrun, 1);
        ack_pulse();
        check("ovr_cleared_valid", valid, 0);
        check("ovr_cleared_flag", overrun, 0);

        // back-to-back with ack on the second commit cycle
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        c2 = cyc;
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
            begin
                while (cyc < c2 + LAT - 1) tick(1);
                rd_ack = 1'b1;
                tick(1);
                rd_ack = 1'b0;
            end
        join
        check("b2b_valid", valid, 1);
        check("b2b_data", data, 8'hFF);
        check("b2b_overrun", overrun, 0);
        ack_pulse();
        check("b2b_acked", valid, 0);

        // reset during data bit 4
        rb  = 8'h77;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) drive_bit(rb[i]);
        rxd = rb[4];
        tick(HALF);
        rst = 1'b1;
        tick(2);
        check_reset_outputs();
        rxd = 1'b1;
        rst = 1'b0;
        tick(20);
        check("rst_no_partial", valid, 0);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        wait_valid(50);
        check("rst_next_data", data, 8'h77);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_valid(50);
        check("parity_err_set", parity_err, 1);
        ack_pulse();
`endif

        // randomized frames
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 6) != 0);
            rp = ($urandom_range(0, 4) == 0);
            send_frame(rb, rs, rp, 1'b1);
            if (!rs) begin
                tick($urandom_range(0, 30));
                rxd = 1'b1;
                tick(4);
            end
            wait_valid(40);
            ack_pulse();
            check("rand_acked", valid, 0);
            tick($urandom_range(0, 20));
        end

        tick(50);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
